sobel_stream_filter: RTL and testbench

Streaming, parametrised successor to the frame-at-a-time `sobel_blackBorder` engine. The block accepts a raster-order grayscale pixel stream over a valid/ready handshake and builds the 3x3 neighbourhood internally from two line buffers. It emits exactly one edge-magnitude pixel per input pixel, with a forced-black border, at a throughput of one pixel per clock. It sits between the grayscale converter and the frame writer in the edge-detection datapath.

---
 rtl/sobel_stream_filter_if.sv | 40 ++++
 rtl/sobel_stream_filter.sv | 191 +++++++++++++++++++
 tb/tb_sobel_stream_filter.sv | 240 ++++++++++++++++++++++++
 3 files changed

// File: rtl/sobel_stream_filter_if.sv
`default_nettype none
// ============================================================================
// Module   : sobel_stream_filter_if
// Purpose  : Pixel-in / edge-out stream bundle for sobel_stream_filter
//            (threshold present only with SOBEL_THRESHOLD_EN)
// Revision : 1.0 - initial release
// ============================================================================
interface sobel_stream_filter_if #(
    parameter int PIX_W = 8
) ();
    logic             in_valid;
    logic             in_ready;
    logic [PIX_W-1:0] in_pixel;
    logic             in_sof;
    logic             out_valid;
    logic             out_ready;
    logic [PIX_W-1:0] out_pixel;
    logic             out_sof;
    logic             out_eol;
`ifdef SOBEL_THRESHOLD_EN
    logic [PIX_W-1:0] threshold;
`endif

    modport slave (
`ifdef SOBEL_THRESHOLD_EN
        input  threshold,
`endif
        input  in_valid, in_pixel, in_sof, out_ready,
        output in_ready, out_valid, out_pixel, out_sof, out_eol
    );

    modport master (
`ifdef SOBEL_THRESHOLD_EN
        output threshold,
`endif
        output in_valid, in_pixel, in_sof, out_ready,
        input  in_ready, out_valid, out_pixel, out_sof, out_eol
    );
endinterface
`default_nettype wire

// File: rtl/sobel_stream_filter.sv
`default_nettype none
// ============================================================================
// Module   : sobel_stream_filter
// Purpose  : Streaming 3x3 Sobel edge magnitude, one pixel per clock, black
//            border. Optional binarisation with SOBEL_THRESHOLD_EN.
// Revision : 1.0 - initial release
// ============================================================================
module sobel_stream_filter #(
    parameter int H_PIXELS = 640,
    parameter int V_LINES  = 480,
    parameter int PIX_W    = 8
) (
    input  wire logic            clk,
    input  wire logic            reset_n,
    sobel_stream_filter_if.slave bus
);
    localparam int c_CW = $clog2(H_PIXELS);
    localparam int c_RW = $clog2(V_LINES);
    localparam int c_KW = $clog2(H_PIXELS * V_LINES + H_PIXELS + 2);
    localparam int c_GW = PIX_W + 3;

    localparam logic [c_CW-1:0] c_COL_LAST     = c_CW'(H_PIXELS - 1);
    localparam logic [c_RW-1:0] c_ROW_LAST     = c_RW'(V_LINES - 1);
    localparam logic [c_KW-1:0] c_K_FIRST_OUT  = c_KW'(H_PIXELS + 1);
    localparam logic [c_KW-1:0] c_K_LAST_IN    = c_KW'(H_PIXELS * V_LINES - 1);
    localparam logic [c_KW-1:0] c_K_LAST_FLUSH = c_KW'(H_PIXELS * V_LINES + H_PIXELS);

    localparam logic [1:0] c_ST_IDLE   = 2'd0;
    localparam logic [1:0] c_ST_STREAM = 2'd1;
    localparam logic [1:0] c_ST_FLUSH  = 2'd2;

    logic [1:0]       r_state;
    logic [c_KW-1:0]  r_k;
    logic [c_CW-1:0]  r_ptr;
    logic [c_RW-1:0]  r_orow;
    logic [c_CW-1:0]  r_ocol;
    logic [PIX_W-1:0] r_win  [0:2][0:2];
    logic [PIX_W-1:0] r_lb0  [0:H_PIXELS-1];
    logic [PIX_W-1:0] r_lb1  [0:H_PIXELS-1];
    logic             r_out_valid;
    logic [PIX_W-1:0] r_out_pixel;
    logic             r_out_sof;
    logic             r_out_eol;

    logic             w_room;
    logic             w_in_ready;
    logic             w_accept;
    logic             w_resync;
    logic             w_flush_step;
    logic             w_shift;
    logic             w_load;
    logic [PIX_W-1:0] w_pix;
    logic [c_CW-1:0]  w_wr_ptr;
    logic [PIX_W-1:0] w_rd0;
    logic [PIX_W-1:0] w_rd1;
    logic [PIX_W-1:0] w_nwin [0:2][0:2];
    logic signed [c_GW-1:0] w_gx;
    logic signed [c_GW-1:0] w_gy;
    logic [c_GW-1:0]  w_ax;
    logic [c_GW-1:0]  w_ay;
    logic [c_GW-1:0]  w_mag;
    logic [PIX_W-1:0] w_sat;
    logic [PIX_W-1:0] w_val;
    logic             w_border;
    logic [PIX_W-1:0] w_result;

    function automatic logic signed [c_GW-1:0] ext(input logic [PIX_W-1:0] v);
        return $signed({3'b000, v});
    endfunction

    assign w_room       = !r_out_valid || bus.out_ready;
    assign w_in_ready   = reset_n && (r_state != c_ST_FLUSH) && w_room;
    assign w_accept     = bus.in_valid && w_in_ready;
    assign w_resync     = w_accept && bus.in_sof;
    assign w_flush_step = (r_state == c_ST_FLUSH) && w_room;
    assign w_shift      = w_resync || ((r_state == c_ST_STREAM) && w_accept) || w_flush_step;
    assign w_load       = !w_resync &&
                          (((r_state == c_ST_STREAM) && w_accept && (r_k >= c_K_FIRST_OUT)) ||
                           w_flush_step);

    // Flush feeds zeros; a resync restarts the frame at column 0.
    assign w_pix    = (r_state == c_ST_FLUSH) ? '0 : bus.in_pixel;
    assign w_wr_ptr = w_resync ? '0 : r_ptr;
    assign w_rd0    = r_lb0[w_wr_ptr];
    assign w_rd1    = r_lb1[w_wr_ptr];

    // Window as it will look after this shift; the result is computed from it
    // so the output register loads on the same edge as the shift.
    always_comb begin
        for (int r = 0; r < 3; r++) begin
            w_nwin[r][0] = r_win[r][1];
            w_nwin[r][1] = r_win[r][2];
            w_nwin[r][2] = '0;
        end
        w_nwin[0][2] = w_rd1;
        w_nwin[1][2] = w_rd0;
        w_nwin[2][2] = w_pix;
    end

    always_comb begin
        w_gx = (ext(w_nwin[0][2]) + (ext(w_nwin[1][2]) <<< 1) + ext(w_nwin[2][2])) -
               (ext(w_nwin[0][0]) + (ext(w_nwin[1][0]) <<< 1) + ext(w_nwin[2][0]));
        w_gy = (ext(w_nwin[2][0]) + (ext(w_nwin[2][1]) <<< 1) + ext(w_nwin[2][2])) -
               (ext(w_nwin[0][0]) + (ext(w_nwin[0][1]) <<< 1) + ext(w_nwin[0][2]));
        w_ax  = w_gx[c_GW-1] ? $unsigned(-w_gx) : $unsigned(w_gx);
        w_ay  = w_gy[c_GW-1] ? $unsigned(-w_gy) : $unsigned(w_gy);
        w_mag = w_ax + w_ay;
        w_sat = (|w_mag[c_GW-1:PIX_W]) ? '1 : w_mag[PIX_W-1:0];
`ifdef SOBEL_THRESHOLD_EN
        w_val = (w_sat >= bus.threshold) ? '1 : '0;
`else
        w_val = w_sat;
`endif
        w_border = (r_orow == '0) || (r_orow == c_ROW_LAST) ||
                   (r_ocol == '0) || (r_ocol == c_COL_LAST);
        w_result = w_border ? '0 : w_val;
    end

    always_ff @(posedge clk) begin
        if (w_shift) begin
            r_lb0[w_wr_ptr] <= w_pix;
            r_lb1[w_wr_ptr] <= w_rd0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state     <= c_ST_IDLE;
            r_k         <= '0;
            r_ptr       <= '0;
            r_orow      <= '0;
            r_ocol      <= '0;
            r_out_valid <= 1'b0;
            r_out_pixel <= '0;
            r_out_sof   <= 1'b0;
            r_out_eol   <= 1'b0;
            for (int r = 0; r < 3; r++) begin
                for (int c = 0; c < 3; c++) begin
                    r_win[r][c] <= '0;
                end
            end
        end else begin
            if (w_shift) begin
                r_win <= w_nwin;
                r_ptr <= (w_wr_ptr == c_COL_LAST) ? '0 : w_wr_ptr + 1'b1;
                r_k   <= w_resync ? c_KW'(1) : r_k + 1'b1;
            end

            if (w_resync) begin
                r_orow <= '0;
                r_ocol <= '0;
            end else if (w_load) begin
                if (r_ocol == c_COL_LAST) begin
                    r_ocol <= '0;
                    r_orow <= (r_orow == c_ROW_LAST) ? '0 : r_orow + 1'b1;
                end else begin
                    r_ocol <= r_ocol + 1'b1;
                end
            end

            if (w_load) begin
                r_out_valid <= 1'b1;
                r_out_pixel <= w_result;
                r_out_sof   <= (r_orow == '0) && (r_ocol == '0);
                r_out_eol   <= (r_ocol == c_COL_LAST);
            end else if (bus.out_ready) begin
                r_out_valid <= 1'b0;
            end

            case (r_state)
                c_ST_IDLE: begin
                    if (w_resync) r_state <= c_ST_STREAM;
                end
                c_ST_STREAM: begin
                    if (!w_resync && w_accept && (r_k == c_K_LAST_IN)) r_state <= c_ST_FLUSH;
                end
                c_ST_FLUSH: begin
                    if (w_flush_step && (r_k == c_K_LAST_FLUSH)) r_state <= c_ST_IDLE;
                end
                default: r_state <= c_ST_IDLE;
            endcase
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.out_pixel = r_out_pixel;
    assign bus.out_sof   = r_out_sof;
    assign bus.out_eol   = r_out_eol;
endmodule
`default_nettype wire

// File: tb/tb_sobel_stream_filter.sv
`default_nettype none
// ============================================================================
// Module   : tb_sobel_stream_filter
// Purpose  : Directed self-checking bench for sobel_stream_filter, 8x6 frames
// Revision : 1.0 - initial release
// ============================================================================
module tb_sobel_stream_filter;
    localparam int H = 8;
    localparam int V = 6;
    localparam int N = H * V;

    typedef struct packed {
        logic [7:0] pix;
        logic       sof;
        logic       eol;
    } out_t;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    sobel_stream_filter_if #(.PIX_W(8)) bus ();

    sobel_stream_filter #(
        .H_PIXELS (H),
        .V_LINES  (V),
        .PIX_W    (8)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    out_t q[$];
    int   tests = 0;
    int   fails = 0;
    bit   rand_ready = 1'b0;
    bit   st_prev = 1'b0;
    logic [9:0] st_data = '0;
`ifdef SOBEL_THRESHOLD_EN
    logic [7:0] thr = 8'd1;
`endif

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Sole driver of out_ready: random when stalling is enabled, else high.
    always @(posedge clk) begin
        #1;
        bus.out_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    // Captures every emitted pixel and verifies outputs hold during stalls.
    always @(negedge clk) begin
        if (!reset_n) begin
            st_prev = 1'b0;
        end else begin
            if (st_prev) begin
                check("hold_valid", 32'(bus.out_valid), 32'd1);
                check("hold_data", 32'({bus.out_pixel, bus.out_sof, bus.out_eol}), 32'(st_data));
            end
            if (bus.out_valid && bus.out_ready)
                q.push_back({bus.out_pixel, bus.out_sof, bus.out_eol});
            st_prev = bus.out_valid && !bus.out_ready;
            st_data = {bus.out_pixel, bus.out_sof, bus.out_eol};
        end
    end

    function automatic logic [7:0] in_pix(input int kind, input int idx);
        int col = idx % H;
        case (kind)
            0:       return 8'd100;
            1:       return 8'(col * 10);
            default: return (col < 4) ? 8'd0 : 8'd255;
        endcase
    endfunction

    function automatic logic [7:0] exp_pix(input int kind, input int idx);
        int row = idx / H;
        int col = idx % H;
        logic [7:0] mag;
        if (row == 0 || row == V - 1 || col == 0 || col == H - 1) return 8'd0;
        case (kind)
            0:       mag = 8'd0;
            1:       mag = 8'd80;
            default: mag = (col == 3 || col == 4) ? 8'd255 : 8'd0;
        endcase
`ifdef SOBEL_THRESHOLD_EN
        return (mag >= thr) ? 8'hFF : 8'h00;
`else
        return mag;
`endif
    endfunction

    task automatic send_pix(input logic [7:0] p, input logic s, input bit gaps);
        int  n;
        bit  acc;
        if (gaps) begin
            bus.in_valid = 1'b0;
            repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
        end
        bus.in_valid = 1'b1;
        bus.in_pixel = p;
        bus.in_sof   = s;
        n = 0;
        forever begin
            @(negedge clk);
            acc = bus.in_ready;
            @(posedge clk);
            #1;
            if (acc) break;
            n++;
            if (n > 200) begin
                check("accept_timeout", 32'(n), 32'd0);
                break;
            end
        end
        bus.in_valid = 1'b0;
        bus.in_sof   = 1'b0;
    endtask

    task automatic send_frame(input int kind, input bit gaps, input bit lat);
        for (int i = 0; i < N; i++) begin
            send_pix(in_pix(kind, i), i == 0, gaps);
            if (i == 0) q.delete();
            if (lat && i == 8) check("lat_idx8_valid", 32'(bus.out_valid), 32'd0);
            if (lat && i == 9) begin
                check("lat_idx9_valid", 32'(bus.out_valid), 32'd1);
                check("lat_idx9_sof", 32'(bus.out_sof), 32'd1);
            end
        end
    endtask

    task automatic drain_and_check(input string tag, input int kind);
        int n = 0;
        while (!(q.size() >= N && bus.out_valid === 1'b0) && n < 1000) begin
            @(negedge clk);
            n++;
        end
        repeat (4) @(negedge clk);
        check({tag, "_count"}, 32'(q.size()), 32'(N));
        for (int i = 0; i < q.size() && i < N; i++) begin
            check($sformatf("%s_pix%0d", tag, i), 32'(q[i].pix), 32'(exp_pix(kind, i)));
            check($sformatf("%s_sof%0d", tag, i), 32'(q[i].sof), 32'(i == 0));
            check($sformatf("%s_eol%0d", tag, i), 32'(q[i].eol), 32'(i % H == H - 1));
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: observed timeout expected finish");
        $fatal(1, "bench timeout");
    end

    initial begin
        bus.in_valid = 1'b0;
        bus.in_pixel = '0;
        bus.in_sof   = 1'b0;
`ifdef SOBEL_THRESHOLD_EN
        bus.threshold = thr;
`endif
        reset_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_valid", 32'(bus.out_valid), 32'd0);
        check("rst_pixel", 32'(bus.out_pixel), 32'd0);
        check("rst_sof", 32'(bus.out_sof), 32'd0);
        check("rst_eol", 32'(bus.out_eol), 32'd0);
        check("rst_in_ready", 32'(bus.in_ready), 32'd0);
        reset_n = 1'b1;
        @(negedge clk);
        check("idle_in_ready", 32'(bus.in_ready), 32'd1);
        @(posedge clk);
        #1;

        send_frame(0, 1'b0, 1'b1);
        drain_and_check("uniform", 0);

        send_frame(1, 1'b0, 1'b0);
        drain_and_check("ramp", 1);

        send_frame(2, 1'b0, 1'b0);
        drain_and_check("step", 2);

        rand_ready = 1'b1;
        send_frame(1, 1'b1, 1'b0);
        rand_ready = 1'b0;
        @(posedge clk);
        #1;
        drain_and_check("ramp_stall", 1);

        for (int i = 0; i < 20; i++) send_pix(in_pix(1, i), i == 0, 1'b0);
        send_frame(0, 1'b0, 1'b0);
        drain_and_check("resync", 0);

        for (int i = 0; i < 30; i++) send_pix(in_pix(1, i), i == 0, 1'b0);
        check("pre_reset_valid", 32'(bus.out_valid), 32'd1);
        reset_n = 1'b0;
        @(negedge clk);
        check("reset_in_ready", 32'(bus.in_ready), 32'd0);
        @(posedge clk);
        #1;
        check("midrst_valid", 32'(bus.out_valid), 32'd0);
        check("midrst_pixel", 32'(bus.out_pixel), 32'd0);
        check("midrst_sof", 32'(bus.out_sof), 32'd0);
        check("midrst_eol", 32'(bus.out_eol), 32'd0);
        reset_n = 1'b1;
        q.delete();
        for (int i = 0; i < 6; i++) send_pix(8'd200, 1'b0, 1'b0);
        repeat (4) @(posedge clk);
        #1;
        check("discard_count", 32'(q.size()), 32'd0);
        check("discard_valid", 32'(bus.out_valid), 32'd0);
        check("discard_in_ready", 32'(bus.in_ready), 32'd1);
        send_frame(1, 1'b0, 1'b0);
        drain_and_check("post_reset", 1);

`ifdef SOBEL_THRESHOLD_EN
        thr = 8'd50;
        bus.threshold = thr;
        send_frame(1, 1'b0, 1'b0);
        drain_and_check("thr50", 1);
        thr = 8'd81;
        bus.threshold = thr;
        send_frame(1, 1'b0, 1'b0);
        drain_and_check("thr81", 1);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
`default_nettype wire
